// File: rtl/mem_arb_ctrl.sv
// Memory arbiter controller: grants one of four requesters by fixed priority
// and sequences a fixed-latency memory access through IDLE/ACCESS/DONE.
module mem_arb_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_fetch,
  input  logic       req_exc,
  input  logic       req_data,
  input  logic       data_we,
  input  logic       req_res,
  output logic [1:0] IorD,
  output logic       mem_wr,
  output logic       ld_ir,
  output logic       ld_mdr,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] iord_q, iord_d;
  logic       we_q, we_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      grant_q <= 4'b0000;
      iord_q  <= 2'b00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      iord_q  <= iord_d;
      we_q    <= we_d;
    end
  end

  // grant_q is one-hot in ack bit order: fetch, exc, data, res
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    iord_d  = iord_q;
    we_d    = we_q;
    mem_wr  = 1'b0;
    ld_ir   = 1'b0;
    ld_mdr  = 1'b0;
    ack     = 4'b0000;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_exc || req_data || req_res || req_fetch) begin
          state_d = ACCESS;
          cnt_d   = LAT_M1;
          we_d    = 1'b0;
          if (req_exc) begin
            grant_d = 4'b0010;
            iord_d  = 2'b01;
          end else if (req_data) begin
            grant_d = 4'b0100;
            iord_d  = 2'b10;
            we_d    = data_we;
          end else if (req_res) begin
            grant_d = 4'b1000;
            iord_d  = 2'b11;
          end else begin
            grant_d = 4'b0001;
            iord_d  = 2'b00;
          end
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_wr = (cnt_q == LAT_M1) && grant_q[2] && we_q;
        if (cnt_q == 3'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        ack     = grant_q;
        ld_ir   = grant_q[0];
        ld_mdr  = grant_q[1] || grant_q[3] || (grant_q[2] && !we_q);
        state_d = IDLE;
        grant_d = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end

  assign IorD = iord_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench for mem_arb_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arb_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] reqs;
  logic       data_we;

  logic [1:0] IorD, iord1, iord7;
  logic       mem_wr, mem_wr1, mem_wr7;
  logic       ld_ir, ld_ir1, ld_ir7;
  logic       ld_mdr, ld_mdr1, ld_mdr7;
  logic [3:0] ack, ack1, ack7;
  logic       busy, busy1, busy7;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arb_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_fetch(reqs[0]), .req_exc(reqs[1]),
    .req_data(reqs[2]), .data_we(data_we), .req_res(reqs[3]),
    .IorD(IorD), .mem_wr(mem_wr), .ld_ir(ld_ir), .ld_mdr(ld_mdr),
    .ack(ack), .busy(busy));

  mem_arb_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_fetch(reqs[0]), .req_exc(reqs[1]),
    .req_data(reqs[2]), .data_we(data_we), .req_res(reqs[3]),
    .IorD(iord1), .mem_wr(mem_wr1), .ld_ir(ld_ir1), .ld_mdr(ld_mdr1),
    .ack(ack1), .busy(busy1));

  mem_arb_ctrl #(.MEM_LAT(7)) dut7 (
    .clk(clk), .reset(reset), .req_fetch(reqs[0]), .req_exc(reqs[1]),
    .req_data(reqs[2]), .data_we(data_we), .req_res(reqs[3]),
    .IorD(iord7), .mem_wr(mem_wr7), .ld_ir(ld_ir7), .ld_mdr(ld_mdr7),
    .ack(ack7), .busy(busy7));

  // Packed view of the LAT=2 outputs: {IorD, mem_wr, ld_ir, ld_mdr, ack, busy}
  function automatic logic [9:0] outs();
    return {IorD, mem_wr, ld_ir, ld_mdr, ack, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (IorD,wr,ir,mdr,ack,busy)", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reqs = 4'($urandom);
    data_we = 1'($urandom);
    reset = 1'b1;
    tick();
    check("reset_cycle1", outs(), 10'b0);
    tick();
    check("reset_cycle2", outs(), 10'b0);
    reqs = 4'b0000;
    reset = 1'b0;
    tick();
    check("idle_after_reset", outs(), 10'b0);
  endtask

  task automatic test_fetch();
    do_reset();
    reqs = 4'b0001;
    tick();
    check("fetch_access1", outs(), {2'b00, 3'b000, 4'b0000, 1'b1});
    tick();
    check("fetch_access2", outs(), {2'b00, 3'b000, 4'b0000, 1'b1});
    tick();
    check("fetch_done", outs(), {2'b00, 3'b010, 4'b0001, 1'b1});
    reqs = 4'b0000;
    tick();
    check("fetch_idle", outs(), {2'b00, 3'b000, 4'b0000, 1'b0});
  endtask

  task automatic test_priority();
    int order [3] = '{1, 2, 0};
    do_reset();
    data_we = 1'b0;
    reqs = 4'b0111;
    foreach (order[k]) begin
      logic [1:0] code;
      logic [3:0] onehot;
      logic       mdr, ir;
      code = 2'(order[k]);
      onehot = 4'b0001 << order[k];
      ir = (order[k] == 0);
      mdr = (order[k] != 0);
      tick();
      check("prio_grant", outs(), {code, 3'b000, 4'b0000, 1'b1});
      tick();
      tick();
      check("prio_done", outs(), {code, 1'b0, ir, mdr, onehot, 1'b1});
      reqs[order[k]] = 1'b0;
      tick();
      check("prio_gap", outs(), {code, 3'b000, 4'b0000, 1'b0});
    end
  endtask

  task automatic test_store();
    do_reset();
    reqs = 4'b0100;
    data_we = 1'b1;
    tick();
    check("store_wr", outs(), {2'b10, 3'b100, 4'b0000, 1'b1});
    data_we = 1'b0;
    reqs = 4'b0000;
    tick();
    check("store_access2", outs(), {2'b10, 3'b000, 4'b0000, 1'b1});
    tick();
    check("store_done", outs(), {2'b10, 3'b000, 4'b0100, 1'b1});
    tick();
    check("store_idle", outs(), {2'b10, 3'b000, 4'b0000, 1'b0});
  endtask

  task automatic test_no_preempt();
    do_reset();
    reqs = 4'b1000;
    tick();
    check("res_grant", outs(), {2'b11, 3'b000, 4'b0000, 1'b1});
    reqs[1] = 1'b1;
    tick();
    check("res_hold", outs(), {2'b11, 3'b000, 4'b0000, 1'b1});
    tick();
    check("res_done", outs(), {2'b11, 3'b001, 4'b1000, 1'b1});
    reqs[3] = 1'b0;
    tick();
    check("res_idle_hold", outs(), {2'b11, 3'b000, 4'b0000, 1'b0});
    tick();
    check("exc_grant", outs(), {2'b01, 3'b000, 4'b0000, 1'b1});
    tick();
    tick();
    check("exc_done", outs(), {2'b01, 3'b001, 4'b0010, 1'b1});
    reqs = 4'b0000;
    tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    reqs = 4'b0001;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_outputs", outs(), 10'b0);
    reset = 1'b0;
    tick();
    check("regrant", outs(), {2'b00, 3'b000, 4'b0000, 1'b1});
    tick();
    tick();
    check("regrant_done", outs(), {2'b00, 3'b010, 4'b0001, 1'b1});
    reqs = 4'b0000;
    tick();
  endtask

  task automatic test_latency();
    int start [3] = '{-1, -1, -1};
    int stop  [3] = '{-1, -1, -1};
    int irs   [3] = '{0, 0, 0};
    int explen [3] = '{2, 3, 8};
    logic [2:0] b, ir;
    do_reset();
    reqs = 4'b0001;
    for (int t = 1; t <= 20; t++) begin
      tick();
      b = {busy7, busy, busy1};
      ir = {ld_ir7, ld_ir, ld_ir1};
      for (int d = 0; d < 3; d++) begin
        if (b[d] && start[d] < 0) start[d] = t;
        if (!b[d] && start[d] >= 0 && stop[d] < 0) stop[d] = t;
        if (ir[d] && stop[d] < 0) irs[d]++;
      end
    end
    reqs = 4'b0000;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (stop[d] < 0 || stop[d] - start[d] != explen[d]) begin
        miscompares++;
        $display("[TB] FAIL latency_busy[%0d]: got %0d cycles expected %0d", d, stop[d] - start[d], explen[d]);
      end
      vectors++;
      if (irs[d] != 1) begin
        miscompares++;
        $display("[TB] FAIL latency_ld_ir[%0d]: got %0d pulses expected 1", d, irs[d]);
      end
    end
    do_reset();
  endtask

  // Reference model: tracks the granted requester and cycles elapsed since grant
  task automatic test_random();
    int cur = -1;
    int age = 0;
    logic mwe = 1'b0;
    logic [1:0] miord = 2'b00;
    logic done, access;
    logic [9:0] exp;
    reset = 1'b1;
    reqs = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (reset) begin
        cur = -1; age = 0; miord = 2'b00; mwe = 1'b0;
      end else if (cur < 0) begin
        if (reqs != 4'b0000) begin
          if (reqs[1]) cur = 1;
          else if (reqs[2]) cur = 2;
          else if (reqs[3]) cur = 3;
          else cur = 0;
          age = 1;
          miord = 2'(cur);
          mwe = (cur == 2) ? data_we : 1'b0;
        end
      end else if (age == LAT + 1) begin
        cur = -1; age = 0;
      end else begin
        age++;
      end
      #1;
      access = (cur >= 0) && (age <= LAT);
      done = (cur >= 0) && (age == LAT + 1);
      exp = {miord,
             access && age == 1 && cur == 2 && mwe,
             done && cur == 0,
             done && (cur == 1 || cur == 3 || (cur == 2 && !mwe)),
             done ? (4'b0001 << cur) : 4'b0000,
             cur >= 0};
      check("random", outs(), exp);
      reset = ($urandom_range(63) == 0);
      data_we = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (reqs[i] && exp[1 + i] && $urandom_range(1) == 0) reqs[i] = 1'b0;
        else if (!reqs[i] && $urandom_range(3) == 0) reqs[i] = 1'b1;
      end
    end
    reset = 1'b0;
    reqs = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    reqs = 4'b0000;
    data_we = 1'b0;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_no_preempt();
    test_reset_abort();
    test_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL take parameter MEM_LAT, default 2, meaning memory read/write latency in cycles (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port req_fetch, input, 1, instruction fetch request (address source PC_out).
REQ-005 SHALL have port req_exc, input, 1, exception vector read request (address source Expction_out).
REQ-006 SHALL have port req_data, input, 1, load/store request (address source ALU_out).
REQ-007 SHALL have port data_we, input, 1, store qualifier for req_data (1 = write, 0 = read).
REQ-008 SHALL have port req_res, input, 1, read request addressed by result.
REQ-009 SHALL have port IorD, output, 2, address mux select: 00 PC_out, 01 Expction_out, 10 ALU_out, 11 result.
REQ-010 SHALL have port mem_wr, output, 1, memory write enable.
REQ-011 SHALL have port ld_ir, output, 1, instruction register load strobe.
REQ-012 SHALL have port ld_mdr, output, 1, memory data register load strobe.
REQ-013 SHALL have port ack, output, 4, one-hot completion pulse: bit0 fetch, bit1 exc, bit2 data, bit3 res.
REQ-014 SHALL have port busy, output, 1, high while an access is granted and not yet completed.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DONE.
REQ-016 In IDLE with any request high, SHALL grant one requester by fixed priority exc > data > res > fetch, latch the grant, load IorD with its code, load cycle counter with MEM_LAT-1, and move to ACCESS next cycle.
REQ-017 In IDLE with no request, SHALL remain in IDLE with IorD holding its last value.
REQ-018 IorD SHALL stay constant from the grant edge through the end of DONE.
REQ-019 In ACCESS, counter SHALL decrement each cycle; move to DONE on the cycle counter equals 0; ACCESS lasts exactly MEM_LAT cycles.
REQ-020 mem_wr SHALL be high only in the first ACCESS cycle and only when the grant is data with data_we sampled 1 at grant time.
REQ-021 In DONE, SHALL pulse the granted ack bit for exactly one cycle; ld_ir high if grant is fetch; ld_mdr high if grant is exc, res, or data read; neither for a store.
REQ-022 DONE SHALL always go to IDLE; minimum turnaround is 1 + MEM_LAT + 1 cycles per access.
REQ-023 busy SHALL be high in ACCESS and DONE, low in IDLE.
REQ-024 An in-flight access SHALL not be preempted; higher-priority requests arriving in ACCESS/DONE wait for IDLE.
REQ-025 Request or data_we deassertion after grant SHALL be ignored; access completes and acks.
REQ-026 Requesters SHALL hold req until their ack; the controller does not queue requests dropped before grant.
REQ-027 A request still high in the IDLE following its ack SHALL be treated as a new request.

Reset
REQ-028 reset high at a clock edge SHALL force state IDLE, counter 0, grant cleared, IorD=00, mem_wr=0, ld_ir=0, ld_mdr=0, ack=0000, busy=0 on the following cycle.
REQ-029 reset during ACCESS or DONE SHALL abort the access with no ack, ld_ir, ld_mdr, or further mem_wr.
REQ-030 reset SHALL take priority over all requests in the same cycle.

Verification (MEM_LAT=2)
REQ-031 Reset then req_fetch=1 -> IorD=00, busy=1 for 3 cycles, ack=0001 and ld_ir=1 on the 3rd cycle after grant edge, busy=0 next.
REQ-032 req_fetch, req_data (data_we=0), req_exc all high in IDLE -> grants in order exc (IorD=01, ack=0010), data (10, 0100, ld_mdr=1), fetch (00, 0001), each with one IDLE cycle between.
REQ-033 req_data with data_we=1 -> mem_wr=1 for exactly one cycle (first ACCESS), ack=0100 and ld_mdr=0 in DONE.
REQ-034 req_res granted, then req_exc raised during ACCESS -> res completes (IorD=11 held, ack=1000) before exc granted.
REQ-035 reset asserted in 2nd ACCESS cycle of a fetch -> no ack/ld_ir, all outputs at reset values next cycle; held req_fetch regranted after reset release.
REQ-036 Repeat REQ-031 with MEM_LAT=1 and 7 -> busy high for 2 and 8 cycles respectively.
